culsans_axi_mem_responder: RTL
==============================

Name: culsans_axi_mem_responder

Overview:
- AXI4/ACE-lite subordinate that terminates one crossbar slave port (DRAM window) in simulation and FPGA bring-up builds.
- Accepts the crossbar-side request struct, backs it with a word-addressed register array, and returns the crossbar-side response struct.
- One outstanding transaction at a time. Supports FIXED, INCR and WRAP bursts, byte strobes, and SLVERR for out-of-window accesses.
- Ignores ACE snoop/bar/domain/awunique fields, so coherent masters behind the interconnect see ordinary memory.

Parameters:
- NumWords, 4096, number of 64-bit words in the backing array (power of two, at least 2).
- BaseAddr, DRAMBase (64'h8000_0000), byte address of word 0.
- req_t, culsans_pkg::req_slv_t, request struct type.
- resp_t, culsans_pkg::resp_slv_t, response struct type.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- axi_req_i  in  $bits(req_t)  AW/W/AR channels plus b_ready and r_ready.
- axi_resp_o  out  $bits(resp_t)  ready signals, B channel and R channel.

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous and active-low.
- Reset values: every axi_resp_o field is 0. The FSM is in IDLE and the arbitration flag prefers read. Array contents are not reset.
- States: IDLE, READ, WRITE, WRESP.
- IDLE:
  - aw_ready and ar_ready are combinationally 1 only when the corresponding channel is granted. w_ready = 0.
  - If only ar_valid is high: grant AR. If only aw_valid is high: grant AW.
  - If both are high: grant the channel not served last (round-robin flag). After reset AR wins the first tie.
  - On AR handshake: latch id, addr, len, size and burst, clear the beat counter, go to READ.
  - On AW handshake: latch the same fields, go to WRITE.
- READ:
  - r_valid asserts the cycle after the AR handshake (registered data). Latency is 1 cycle.
  - Each beat drives r.id = latched id, r.data = the array word, r.last = (beat == len), r.user = 0.
  - r.resp[1:0] = OKAY, or SLVERR with data 0 if the beat address is outside the window. r.resp[3:2] = 0 (PassDirty = 0, IsShared = 0).
  - The beat advances on r_valid && r_ready; the next beat is presented in the same cycle, so throughput is one beat per cycle.
  - r_valid and r payload are held stable while r_ready = 0.
  - After the last beat handshake, go to IDLE and set the round-robin flag to prefer write.
- WRITE:
  - w_ready = 1. Each w_valid handshake writes the array word byte-wise under w.strb; writes to out-of-window beats are dropped.
  - Any out-of-window beat sets a sticky error flag.
  - The burst ends on the beat where counter == len, regardless of w.last. A mismatch between w.last and the counter fires a simulation assertion.
  - Then go to WRESP.
- WRESP:
  - b_valid = 1, b.id = latched id, b.resp = SLVERR if the error flag is set, else OKAY. b.user = 0.
  - On b_ready handshake: clear the error flag, go to IDLE, prefer read.
- Beat address:
  - Word index = (addr - BaseAddr) >> 3. The beat is in window iff addr >= BaseAddr and index < NumWords.
  - FIXED: address constant.
  - INCR: address += 1 << size.
  - WRAP: boundary = (len+1) << size, with len+1 in {2,4,8,16}. next = (addr & ~(boundary-1)) | ((addr + (1<<size)) & (boundary-1)).
  - For size < 3, reads return the full 64-bit word; writes rely on strobes.
- Unsupported inputs:
  - aw.atop != 0 is unsupported; assertion.
  - lock = 1 is treated as a normal access and answered OKAY, never EXOKAY.
- Simultaneity and reset:
  - AW and AR are never both accepted in one cycle.
  - W beats arriving in IDLE wait because w_ready = 0.
  - Reset mid-burst drops the transaction and returns the FSM to IDLE. The array keeps any beats already written.

Test Plan:
- Single write then read: AW addr 0x8000_0010, len 0, size 3, W data 0xDEAD_BEEF_0123_4567, strb 0xFF -> B OKAY. Then AR to the same address -> R data 0xDEAD_BEEF_0123_4567, last = 1, resp 0, r_valid one cycle after the AR handshake.
- INCR burst: write len 3 at 0x8000_0100 with data 1,2,3,4 -> B OKAY. A read burst returns 1,2,3,4 back-to-back with r_ready held 1, last only on beat 4.
- WRAP burst: read len 3, size 3, addr 0x8000_0110 -> beats return words at 0x110, 0x118, 0x100, 0x108.
- Strobe and error:
  - Write strb 0x0F, data 0xFFFF_FFFF_FFFF_FFFF over 0 -> word reads 0x0000_0000_FFFF_FFFF.
  - Write to 0x7FFF_FFF8 -> B SLVERR, array unchanged.
  - Read at BaseAddr + 8*NumWords -> R SLVERR, data 0.
- Arbitration and backpressure:
  - aw_valid and ar_valid both high from reset -> AR granted first, AW next.
  - r_ready toggling 1/0 -> payload held stable, no beat lost or duplicated.
  - b_ready held 0 for 5 cycles -> b_valid held, no new grant.
- Reset mid-burst: assert rst_ni low during beat 2 of a len-7 read -> all outputs 0 within the same cycle. After release a new AR completes normally.

Source files
------------

// File: rtl/culsans_axi_mem_responder.sv
// Crossbar-side AXI4/ACE-lite type package and a single-outstanding memory responder
// that backs one DRAM window with a word-addressed array (FIXED/INCR/WRAP, strobes, SLVERR).

package culsans_pkg;
  localparam int unsigned IdWidth = 4;
  localparam logic [63:0] DRAMBase = 64'h8000_0000;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [63:0]        addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic [3:0]         qos;
    logic [5:0]         atop;
    logic               user;
    logic [2:0]         snoop;
    logic [1:0]         bar;
    logic [1:0]         domain;
    logic               awunique;
  } aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [63:0]        addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic [3:0]         qos;
    logic               user;
    logic [3:0]         snoop;
    logic [1:0]         bar;
    logic [1:0]         domain;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
    logic               user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [63:0]        data;
    logic [3:0]         resp;
    logic               last;
    logic               user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_slv_t;
endpackage

// Handshake rule for every channel: a beat transfers on the rising clk_i edge where
// valid and ready are both high; a source holds valid and payload stable until then.
module culsans_axi_mem_responder #(
  parameter int unsigned NumWords = 4096,
  parameter logic [63:0] BaseAddr = culsans_pkg::DRAMBase,
  parameter type         req_t    = culsans_pkg::req_slv_t,
  parameter type         resp_t   = culsans_pkg::resp_slv_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  axi_req_i,
  output resp_t axi_resp_o
);
  localparam int unsigned IdxW = $clog2(NumWords);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_e;

  state_e                          state_q;
  logic [culsans_pkg::IdWidth-1:0] id_q;
  logic [63:0]                     addr_q;
  logic [7:0]                      len_q, beat_q;
  logic [2:0]                      size_q;
  logic [1:0]                      burst_q;
  logic                            err_q, prefer_wr_q;
  logic                            r_valid_q, b_valid_q;
  culsans_pkg::r_chan_t            r_q;
  culsans_pkg::b_chan_t            b_q;

  logic [63:0] mem [NumWords];

  function automatic logic in_window(input logic [63:0] a);
    logic [63:0] off;
    off = a - BaseAddr;
    return (a >= BaseAddr) && ((off >> 3) < 64'(NumWords));
  endfunction

  function automatic logic [IdxW-1:0] word_index(input logic [63:0] a);
    logic [63:0] off;
    off = a - BaseAddr;
    return off[IdxW+2:3];
  endfunction

  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] step, bound;
    step  = 64'd1 << size;
    bound = (64'(len) + 64'd1) << size;
    if (burst == BurstFixed)     return a;
    else if (burst == BurstIncr) return a + step;
    else                         return (a & ~(bound - 64'd1)) | ((a + step) & (bound - 64'd1));
  endfunction

  logic        grant_ar, grant_aw, ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic [63:0] nxt_addr, rd_addr, rd_word;
  logic        rd_in, wr_in, mem_we;
  logic [IdxW-1:0] wr_idx;

  // Round-robin tie break: the flag names the channel that was not served last.
  always_comb begin
    grant_ar = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !prefer_wr_q);
    grant_aw = axi_req_i.aw_valid && !grant_ar;
    ar_hs    = (state_q == IDLE) && grant_ar;
    aw_hs    = (state_q == IDLE) && grant_aw;
    w_hs     = (state_q == WRITE) && axi_req_i.w_valid;
    r_hs     = r_valid_q && axi_req_i.r_ready;
    b_hs     = b_valid_q && axi_req_i.b_ready;
    nxt_addr = next_addr(addr_q, size_q, len_q, burst_q);
    rd_addr  = (state_q == IDLE) ? axi_req_i.ar.addr : nxt_addr;
    rd_in    = in_window(rd_addr);
    rd_word  = rd_in ? mem[word_index(rd_addr)] : 64'd0;
    wr_in    = in_window(addr_q);
    wr_idx   = word_index(addr_q);
    mem_we   = w_hs && wr_in;
  end

  // Ready lines are gated with reset so the port reads all-zero while rst_ni is low.
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = rst_ni && aw_hs;
    axi_resp_o.ar_ready = rst_ni && ar_hs;
    axi_resp_o.w_ready  = rst_ni && (state_q == WRITE);
    axi_resp_o.b_valid  = b_valid_q;
    axi_resp_o.b        = b_q;
    axi_resp_o.r_valid  = r_valid_q;
    axi_resp_o.r        = r_q;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (axi_req_i.w.strb[i]) mem[wr_idx][8*i +: 8] <= axi_req_i.w.data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      prefer_wr_q <= 1'b0;
      r_valid_q   <= 1'b0;
      r_q         <= '0;
      b_valid_q   <= 1'b0;
      b_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            id_q      <= axi_req_i.ar.id;
            addr_q    <= axi_req_i.ar.addr;
            len_q     <= axi_req_i.ar.len;
            size_q    <= axi_req_i.ar.size;
            burst_q   <= axi_req_i.ar.burst;
            beat_q    <= '0;
            r_valid_q <= 1'b1;
            r_q.id    <= axi_req_i.ar.id;
            r_q.data  <= rd_word;
            r_q.resp  <= {2'b00, rd_in ? RespOkay : RespSlvErr};
            r_q.last  <= (axi_req_i.ar.len == 8'd0);
            r_q.user  <= 1'b0;
            state_q   <= READ;
          end else if (aw_hs) begin
            id_q    <= axi_req_i.aw.id;
            addr_q  <= axi_req_i.aw.addr;
            len_q   <= axi_req_i.aw.len;
            size_q  <= axi_req_i.aw.size;
            burst_q <= axi_req_i.aw.burst;
            beat_q  <= '0;
            state_q <= WRITE;
          end
        end
        READ: begin
          if (r_hs) begin
            if (r_q.last) begin
              r_valid_q   <= 1'b0;
              r_q         <= '0;
              prefer_wr_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              beat_q   <= beat_q + 8'd1;
              addr_q   <= nxt_addr;
              r_q.data <= rd_word;
              r_q.resp <= {2'b00, rd_in ? RespOkay : RespSlvErr};
              r_q.last <= ((beat_q + 8'd1) == len_q);
            end
          end
        end
        WRITE: begin
          if (w_hs) begin
            if (!wr_in) err_q <= 1'b1;
            if (beat_q == len_q) begin
              b_valid_q <= 1'b1;
              b_q.id    <= id_q;
              b_q.resp  <= (err_q || !wr_in) ? RespSlvErr : RespOkay;
              b_q.user  <= 1'b0;
              state_q   <= WRESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= nxt_addr;
            end
          end
        end
        WRESP: begin
          if (b_hs) begin
            b_valid_q   <= 1'b0;
            b_q         <= '0;
            err_q       <= 1'b0;
            prefer_wr_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ACE snoop/barrier/domain and AXI sideband fields are accepted but carry no meaning here.
  logic unused_fields;
  assign unused_fields = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                           axi_req_i.aw.qos, axi_req_i.aw.user, axi_req_i.aw.snoop,
                           axi_req_i.aw.bar, axi_req_i.aw.domain, axi_req_i.aw.awunique,
                           axi_req_i.aw.atop, axi_req_i.ar.lock, axi_req_i.ar.cache,
                           axi_req_i.ar.prot, axi_req_i.ar.qos, axi_req_i.ar.user,
                           axi_req_i.ar.snoop, axi_req_i.ar.bar, axi_req_i.ar.domain,
                           axi_req_i.w.user, axi_req_i.w.last};

  a_wlast_matches_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_hs |-> (axi_req_i.w.last == (beat_q == len_q)));
  a_no_atomics: assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_hs |-> (axi_req_i.aw.atop == 6'd0));
  a_single_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(axi_resp_o.aw_ready && axi_resp_o.ar_ready));
endmodule
